decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- LC-3b pipeline decode stage, directly downstream of the fetch stage.
- Owns the DE latch, the 8x16 register file, the NZP condition-code register and the AGEX latch.
- Decodes the DE instruction, reads operands with writeback bypass, and detects register and CC dependencies against in-flight instructions.
- Drives dep_stall and v_de_br_stall back to fetch and a one-cycle-latency AGEX latch forward.

Parameters:
RESET_CC, 3'b010, condition-code value after reset (N,Z,P ordering).

Ports:
clk  in  1  pipeline clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
ld_de  in  1  load DE latch (from fetch)
de_npc_in  in  16  next PC from fetch
de_ir_in  in  16  instruction from fetch
de_v_in  in  1  valid from fetch
mem_stall  in  1  downstream memory stall; freezes AGEX latch
v_mem_ld_reg  in  1  MEM-stage instruction is valid and writes a register
mem_dr  in  3  MEM-stage destination register
v_mem_ld_cc  in  1  MEM-stage instruction is valid and sets CC
sr_ld_reg  in  1  writeback register enable
sr_dr  in  3  writeback destination register
sr_data  in  16  writeback data
sr_ld_cc  in  1  writeback CC enable; NZP derived from sr_data
dep_stall  out  1  DE instruction blocked by a dependency (combinational)
v_de_br_stall  out  1  valid control-flow instruction in DE (combinational)
agex_v  out  1  AGEX valid
agex_npc  out  16  AGEX next PC
agex_ir  out  16  AGEX instruction
agex_sr1  out  16  AGEX operand 1
agex_sr2  out  16  AGEX operand 2 / store data
agex_cc  out  3  AGEX condition codes, sampled in decode
agex_dr  out  3  AGEX destination register
agex_ld_reg  out  1  AGEX instruction writes a register
agex_ld_cc  out  1  AGEX instruction sets CC

Behaviour:
- Reset (asynchronous, rst_n=0), effective immediately and regardless of clock:
  - DE latch and AGEX latch: all fields 0, de_v=0, agex_v=0.
  - R0-R7 = 16'h0000; CC = RESET_CC; agex_cc = RESET_CC.
  - Reset mid-stall discards all in-flight state.
- DE latch: loads npc/ir/v on posedge when ld_de=1, otherwise holds.
- Decode uses op=ir[15:12]:
  - SR1 = ir[8:6]; used by ADD/AND/XOR (0001/0101/1001), SHF 1101, LDB/LDW 0010/0110, STB/STW 0011/0111, JMP 1100, and JSR 0100 when ir[11]=0.
  - SR2 address = ir[2:0] for ADD/AND/XOR with ir[5]=0 (used); = ir[11:9] for STB/STW (used); otherwise ir[2:0] (unused).
  - DR = ir[11:9] for ADD/AND/XOR/SHF/LDB/LDW/LEA(1110); DR = 7 for JSR and TRAP(1111). ld_reg=1 only for these opcodes.
  - ld_cc=1 for ADD/AND/XOR/SHF/LDB/LDW; LEA does not set CC.
  - BR (0000) uses CC. Opcodes 1000, 1010, 1011 use no sources and write nothing.
- Register read:
  - Combinational, with write-first bypass: if sr_ld_reg=1 and sr_dr equals a read address, that operand is sr_data.
  - CC read is bypassed the same way when sr_ld_cc=1.
  - sr_data NZP: N = bit15; Z = all zero; P otherwise.
- Register file / CC write: on posedge when sr_ld_reg / sr_ld_cc is 1.
- dep_stall = de_v AND (any used source, or CC for BR, matches a producer).
  - Producers are the AGEX latch (agex_v & agex_ld_reg / agex_ld_cc) and the MEM inputs.
  - The SR stage is never a hazard because of the bypass.
  - Writes to R0 are not special-cased; R0 is an ordinary register.
- v_de_br_stall = de_v AND op ∈ {BR, JMP, JSR, TRAP}; asserted even while dep_stall=1.
- AGEX latch, ld = ~mem_stall:
  - Loads npc, ir, sr1, sr2, cc, dr, ld_reg, ld_cc, with agex_v <= de_v & ~dep_stall.
  - When agex_v is loaded 0 (bubble), agex_ld_reg and agex_ld_cc are also loaded 0.
  - When mem_stall=1, all AGEX fields hold. dep_stall is still computed, and the DE latch obeys ld_de independently.
- Simultaneous events:
  - Writeback to a register read in the same cycle is bypassed.
  - A writeback to a register that AGEX/MEM also targets still stalls on the AGEX/MEM match.
- de_v=0 forces dep_stall=0 and v_de_br_stall=0.

Test Plan:
1. Reset: hold stall state with agex_v=1, pulse rst_n=0 between clock edges -> immediately agex_v=0, agex_cc=3'b010, dep_stall=0; a subsequent read of R5 returns 0x0000.
2. Decode: write R2=0x0005, R3=0x0007 via SR port; load DE 0x1283 (ADD R1,R2,R3), v=1 -> after one posedge agex_v=1, agex_sr1=0x0005, agex_sr2=0x0007, agex_dr=1, agex_ld_reg=1, agex_ld_cc=1.
3. Bypass: DE=0x1283 while sr_ld_reg=1, sr_dr=2, sr_data=0x00AA in the same cycle -> agex_sr1=0x00AA; sr_ld_cc=1 with sr_data=0x8000 in the same cycle -> agex_cc=3'b100.
4. RAW stall, after ADD R1 is in AGEX and DE=0x1861 (ADD R4,R1,#1):
   - Initially dep_stall=1 and the next AGEX is a bubble.
   - Then v_mem_ld_reg=1, mem_dr=1 -> still stalled.
   - v_mem_ld_reg=0 -> dep_stall=0, agex_v=1 next edge.
   - Repeat with immediate form ir[5]=1, R1 only in SR2 field -> no stall.
5. Branch: DE=0x0405 (BRz) with AGEX holding a valid ld_cc instruction -> dep_stall=1, v_de_br_stall=1. With no CC producers in flight -> dep_stall=0, v_de_br_stall=1, and agex_cc equals the current CC.
6. mem_stall=1 for 3 cycles with DE valid -> all AGEX outputs unchanged. On release, DE contents load with agex_v=1. STW 0x7283 reads R1 into agex_sr2 and stalls on mem_dr=1.

Source files
------------

// File: rtl/decode_stage.sv
// LC-3b decode stage: DE latch, 8x16 register file, NZP register and AGEX latch.
// Operands are read with writeback bypass; RAW/CC hazards against AGEX and MEM raise dep_stall.
module decode_stage #(
   parameter logic [2:0] RESET_CC = 3'b010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_de,
   input  logic [15:0] de_npc_in,
   input  logic [15:0] de_ir_in,
   input  logic        de_v_in,
   input  logic        mem_stall,
   input  logic        v_mem_ld_reg,
   input  logic [2:0]  mem_dr,
   input  logic        v_mem_ld_cc,
   input  logic        sr_ld_reg,
   input  logic [2:0]  sr_dr,
   input  logic [15:0] sr_data,
   input  logic        sr_ld_cc,
   output logic        dep_stall,
   output logic        v_de_br_stall,
   output logic        agex_v,
   output logic [15:0] agex_npc,
   output logic [15:0] agex_ir,
   output logic [15:0] agex_sr1,
   output logic [15:0] agex_sr2,
   output logic [2:0]  agex_cc,
   output logic [2:0]  agex_dr,
   output logic        agex_ld_reg,
   output logic        agex_ld_cc
);

   typedef struct packed {
      logic        v;
      logic [15:0] npc;
      logic [15:0] ir;
      logic [15:0] sr1;
      logic [15:0] sr2;
      logic [2:0]  cc;
      logic [2:0]  dr;
      logic        ld_reg;
      logic        ld_cc;
   } agex_t;

   logic             de_v;
   logic [15:0]      de_npc;
   logic [15:0]      de_ir;
   logic [7:0][15:0] rf;
   logic [2:0]       cc;
   agex_t            ag;
   agex_t            ag_d;

   // ---------------- DE latch ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_v   <= 1'b0;
         de_npc <= '0;
         de_ir  <= '0;
      end else if (ld_de) begin
         de_v   <= de_v_in;
         de_npc <= de_npc_in;
         de_ir  <= de_ir_in;
      end
   end

   // ---------------- decode ----------------
   logic [3:0] op;
   logic       is_alu, is_shf, is_ld, is_st, is_jmp, is_jsr, is_trap, is_lea, is_br;
   logic       sr1_used, sr2_used, dec_ld_reg, dec_ld_cc;
   logic [2:0] sr1_addr, sr2_addr, dec_dr;

   assign op      = de_ir[15:12];
   assign is_alu  = (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1001);
   assign is_shf  = (op == 4'b1101);
   assign is_ld   = (op == 4'b0010) || (op == 4'b0110);
   assign is_st   = (op == 4'b0011) || (op == 4'b0111);
   assign is_jmp  = (op == 4'b1100);
   assign is_jsr  = (op == 4'b0100);
   assign is_trap = (op == 4'b1111);
   assign is_lea  = (op == 4'b1110);
   assign is_br   = (op == 4'b0000);

   assign sr1_addr   = de_ir[8:6];
   // Stores carry their data register in the DR field.
   assign sr2_addr   = is_st ? de_ir[11:9] : de_ir[2:0];
   assign sr1_used   = is_alu | is_shf | is_ld | is_st | is_jmp | (is_jsr & ~de_ir[11]);
   assign sr2_used   = (is_alu & ~de_ir[5]) | is_st;
   assign dec_ld_reg = is_alu | is_shf | is_ld | is_lea | is_jsr | is_trap;
   assign dec_ld_cc  = is_alu | is_shf | is_ld;
   assign dec_dr     = (is_jsr | is_trap) ? 3'd7 : de_ir[11:9];

   // ---------------- operand read with writeback bypass ----------------
   logic [2:0]  sr_nzp, cc_rd;
   logic [15:0] sr1_rd, sr2_rd;

   assign sr_nzp = sr_data[15]       ? 3'b100 :
                   (sr_data == 16'h0) ? 3'b010 : 3'b001;
   assign sr1_rd = (sr_ld_reg && (sr_dr == sr1_addr)) ? sr_data : rf[sr1_addr];
   assign sr2_rd = (sr_ld_reg && (sr_dr == sr2_addr)) ? sr_data : rf[sr2_addr];
   assign cc_rd  = sr_ld_cc ? sr_nzp : cc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf <= '0;
         cc <= RESET_CC;
      end else begin
         if (sr_ld_reg) rf[sr_dr] <= sr_data;
         if (sr_ld_cc)  cc <= sr_nzp;
      end
   end

   // ---------------- dependency detection ----------------
   // SR-stage writes are covered by the bypass, so only AGEX and MEM are producers.
   logic sr1_hit, sr2_hit, cc_hit;

   assign sr1_hit = (ag.v & ag.ld_reg & (ag.dr == sr1_addr)) |
                    (v_mem_ld_reg & (mem_dr == sr1_addr));
   assign sr2_hit = (ag.v & ag.ld_reg & (ag.dr == sr2_addr)) |
                    (v_mem_ld_reg & (mem_dr == sr2_addr));
   assign cc_hit  = (ag.v & ag.ld_cc) | v_mem_ld_cc;

   assign dep_stall = de_v & ((sr1_used & sr1_hit) | (sr2_used & sr2_hit) |
                              (is_br & cc_hit));
   assign v_de_br_stall = de_v & (is_br | is_jmp | is_jsr | is_trap);

   // ---------------- AGEX latch ----------------
   always_comb begin
      ag_d        = '0;
      ag_d.v      = de_v & ~dep_stall;
      ag_d.npc    = de_npc;
      ag_d.ir     = de_ir;
      ag_d.sr1    = sr1_rd;
      ag_d.sr2    = sr2_rd;
      ag_d.cc     = cc_rd;
      ag_d.dr     = dec_dr;
      ag_d.ld_reg = ag_d.v & dec_ld_reg;
      ag_d.ld_cc  = ag_d.v & dec_ld_cc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ag    <= '0;
         ag.cc <= RESET_CC;
      end else if (!mem_stall) begin
         ag <= ag_d;
      end
   end

   assign agex_v      = ag.v;
   assign agex_npc    = ag.npc;
   assign agex_ir     = ag.ir;
   assign agex_sr1    = ag.sr1;
   assign agex_sr2    = ag.sr2;
   assign agex_cc     = ag.cc;
   assign agex_dr     = ag.dr;
   assign agex_ld_reg = ag.ld_reg;
   assign agex_ld_cc  = ag.ld_cc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: random stimulus against an instruction-level model,
// plus directed scenarios with hand-computed expectations.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ld_de = 1'b0;
   logic [15:0] de_npc_in = '0;
   logic [15:0] de_ir_in = '0;
   logic        de_v_in = 1'b0;
   logic        mem_stall = 1'b0;
   logic        v_mem_ld_reg = 1'b0;
   logic [2:0]  mem_dr = '0;
   logic        v_mem_ld_cc = 1'b0;
   logic        sr_ld_reg = 1'b0;
   logic [2:0]  sr_dr = '0;
   logic [15:0] sr_data = '0;
   logic        sr_ld_cc = 1'b0;
   logic        dep_stall, v_de_br_stall, agex_v, agex_ld_reg, agex_ld_cc;
   logic [15:0] agex_npc, agex_ir, agex_sr1, agex_sr2;
   logic [2:0]  agex_cc, agex_dr;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .ld_de(ld_de), .de_npc_in(de_npc_in),
      .de_ir_in(de_ir_in), .de_v_in(de_v_in), .mem_stall(mem_stall),
      .v_mem_ld_reg(v_mem_ld_reg), .mem_dr(mem_dr), .v_mem_ld_cc(v_mem_ld_cc),
      .sr_ld_reg(sr_ld_reg), .sr_dr(sr_dr), .sr_data(sr_data), .sr_ld_cc(sr_ld_cc),
      .dep_stall(dep_stall), .v_de_br_stall(v_de_br_stall), .agex_v(agex_v),
      .agex_npc(agex_npc), .agex_ir(agex_ir), .agex_sr1(agex_sr1),
      .agex_sr2(agex_sr2), .agex_cc(agex_cc), .agex_dr(agex_dr),
      .agex_ld_reg(agex_ld_reg), .agex_ld_cc(agex_ld_cc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level model ----------------
   logic [15:0] m_rf [8];
   logic [2:0]  m_cc;
   logic        m_de_v;
   logic [15:0] m_de_ir, m_de_npc;
   logic        m_ag_v, m_ag_ld_reg, m_ag_ld_cc;
   logic [15:0] m_ag_npc, m_ag_ir, m_ag_sr1, m_ag_sr2;
   logic [2:0]  m_ag_cc, m_ag_dr;

   function automatic logic [2:0] nzp(input logic [15:0] d);
      if (d[15]) return 3'b100;
      if (d == 16'h0) return 3'b010;
      return 3'b001;
   endfunction

   // What an instruction reads and writes, straight from the opcode table.
   function automatic void info(input logic [15:0] ir, output bit u1, output bit u2,
                                output logic [2:0] a2, output bit ucc, output bit lr,
                                output bit lc, output logic [2:0] dr, output bit ctl);
      int o;
      bit alu;
      o   = int'(ir[15:12]);
      alu = (o == 1) || (o == 5) || (o == 9);
      u1  = alu || o == 13 || o == 2 || o == 6 || o == 3 || o == 7 || o == 12 ||
            (o == 4 && !ir[11]);
      u2  = (alu && !ir[5]) || o == 3 || o == 7;
      a2  = (o == 3 || o == 7) ? ir[11:9] : ir[2:0];
      ucc = (o == 0);
      lr  = alu || o == 13 || o == 2 || o == 6 || o == 14 || o == 4 || o == 15;
      lc  = alu || o == 13 || o == 2 || o == 6;
      dr  = (o == 4 || o == 15) ? 3'd7 : ir[11:9];
      ctl = (o == 0 || o == 12 || o == 4 || o == 15);
   endfunction

   function automatic logic [15:0] rd(input logic [2:0] a);
      return (sr_ld_reg && sr_dr == a) ? sr_data : m_rf[a];
   endfunction

   function automatic bit produced(input logic [2:0] r);
      return (m_ag_v && m_ag_ld_reg && m_ag_dr == r) || (v_mem_ld_reg && mem_dr == r);
   endfunction

   function automatic bit exp_dep();
      bit u1, u2, ucc, lr, lc, ctl;
      logic [2:0] a2, dr;
      info(m_de_ir, u1, u2, a2, ucc, lr, lc, dr, ctl);
      return m_de_v && ((u1 && produced(m_de_ir[8:6])) || (u2 && produced(a2)) ||
             (ucc && ((m_ag_v && m_ag_ld_cc) || v_mem_ld_cc)));
   endfunction

   function automatic bit exp_br();
      bit u1, u2, ucc, lr, lc, ctl;
      logic [2:0] a2, dr;
      info(m_de_ir, u1, u2, a2, ucc, lr, lc, dr, ctl);
      return m_de_v && ctl;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit u1, u2, ucc, lr, lc, ctl, go;
      logic [2:0] a2, dr;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_rf[i] <= 16'h0;
         m_cc <= 3'b010;
         m_de_v <= 1'b0; m_de_ir <= '0; m_de_npc <= '0;
         m_ag_v <= 1'b0; m_ag_npc <= '0; m_ag_ir <= '0; m_ag_sr1 <= '0; m_ag_sr2 <= '0;
         m_ag_cc <= 3'b010; m_ag_dr <= '0; m_ag_ld_reg <= 1'b0; m_ag_ld_cc <= 1'b0;
      end else begin
         info(m_de_ir, u1, u2, a2, ucc, lr, lc, dr, ctl);
         go = m_de_v && !exp_dep();
         if (!mem_stall) begin
            m_ag_v      <= go;
            m_ag_npc    <= m_de_npc;
            m_ag_ir     <= m_de_ir;
            m_ag_sr1    <= rd(m_de_ir[8:6]);
            m_ag_sr2    <= rd(a2);
            m_ag_cc     <= sr_ld_cc ? nzp(sr_data) : m_cc;
            m_ag_dr     <= dr;
            m_ag_ld_reg <= go && lr;
            m_ag_ld_cc  <= go && lc;
         end
         if (ld_de) begin
            m_de_v <= de_v_in; m_de_ir <= de_ir_in; m_de_npc <= de_npc_in;
         end
         if (sr_ld_reg) m_rf[sr_dr] <= sr_data;
         if (sr_ld_cc) m_cc <= nzp(sr_data);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("dep_stall", {31'b0, dep_stall}, {31'b0, exp_dep()});
         chk("v_de_br_stall", {31'b0, v_de_br_stall}, {31'b0, exp_br()});
         chk("agex_v", {31'b0, agex_v}, {31'b0, m_ag_v});
         chk("agex_npc", {16'b0, agex_npc}, {16'b0, m_ag_npc});
         chk("agex_ir", {16'b0, agex_ir}, {16'b0, m_ag_ir});
         chk("agex_sr1", {16'b0, agex_sr1}, {16'b0, m_ag_sr1});
         chk("agex_sr2", {16'b0, agex_sr2}, {16'b0, m_ag_sr2});
         chk("agex_cc", {29'b0, agex_cc}, {29'b0, m_ag_cc});
         chk("agex_ld_reg", {31'b0, agex_ld_reg}, {31'b0, m_ag_ld_reg});
         chk("agex_ld_cc", {31'b0, agex_ld_cc}, {31'b0, m_ag_ld_cc});
         if (m_ag_ld_reg) chk("agex_dr", {29'b0, agex_dr}, {29'b0, m_ag_dr});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ld_de = 1'b0; mem_stall = 1'b0; v_mem_ld_reg = 1'b0; v_mem_ld_cc = 1'b0;
      sr_ld_reg = 1'b0; sr_ld_cc = 1'b0;
   endtask

   task automatic load_de(input logic [15:0] ir, input logic [15:0] npc);
      ld_de = 1'b1; de_ir_in = ir; de_npc_in = npc; de_v_in = 1'b1;
   endtask

   initial begin
      logic [15:0] ir;
      #1 rst_n = 1'b0;
      #1;
      chk("rst agex_v", {31'b0, agex_v}, 32'h0);
      chk("rst agex_cc", {29'b0, agex_cc}, 32'h2);
      chk("rst dep_stall", {31'b0, dep_stall}, 32'h0);
      chk("rst v_de_br_stall", {31'b0, v_de_br_stall}, 32'h0);
      chk("rst agex_ir", {16'b0, agex_ir}, 32'h0);
      #10 rst_n = 1'b1;
      chk_en = 1'b1;
      cyc();

      // ADD R1,R2,R3 with R2=5, R3=7
      sr_ld_reg = 1'b1; sr_dr = 3'd2; sr_data = 16'h0005; cyc();
      sr_dr = 3'd3; sr_data = 16'h0007; cyc();
      sr_ld_reg = 1'b0;
      load_de(16'h1283, 16'h3002); cyc();
      ld_de = 1'b0; cyc();
      chk("add agex_v", {31'b0, agex_v}, 32'h1);
      chk("add sr1", {16'b0, agex_sr1}, 32'h5);
      chk("add sr2", {16'b0, agex_sr2}, 32'h7);
      chk("add dr", {29'b0, agex_dr}, 32'h1);
      chk("add ld_reg", {31'b0, agex_ld_reg}, 32'h1);
      chk("add ld_cc", {31'b0, agex_ld_cc}, 32'h1);

      // same-cycle writeback bypass of a register and of CC
      sr_ld_reg = 1'b1; sr_dr = 3'd2; sr_data = 16'h00AA; cyc();
      chk("bypass sr1", {16'b0, agex_sr1}, 32'hAA);
      sr_ld_reg = 1'b0; sr_ld_cc = 1'b1; sr_data = 16'h8000; cyc();
      chk("bypass cc", {29'b0, agex_cc}, 32'h4);
      sr_ld_cc = 1'b0;

      // RAW: ADD R4,R1,#1 behind ADD R1
      load_de(16'h1861, 16'h3004); cyc();
      ld_de = 1'b0; #1;
      chk("raw agex stall", {31'b0, dep_stall}, 32'h1);
      cyc();
      chk("raw bubble", {31'b0, agex_v}, 32'h0);
      chk("raw bubble ld_reg", {31'b0, agex_ld_reg}, 32'h0);
      v_mem_ld_reg = 1'b1; mem_dr = 3'd1; #1;
      chk("raw mem stall", {31'b0, dep_stall}, 32'h1);
      v_mem_ld_reg = 1'b0; #1;
      chk("raw clear", {31'b0, dep_stall}, 32'h0);
      cyc();
      chk("raw issue", {31'b0, agex_v}, 32'h1);
      chk("raw issue dr", {29'b0, agex_dr}, 32'h4);
      load_de(16'h18A1, 16'h3006); cyc();
      ld_de = 1'b0; v_mem_ld_reg = 1'b1; mem_dr = 3'd1; #1;
      chk("imm no stall", {31'b0, dep_stall}, 32'h0);

      // BRz behind a CC producer
      v_mem_ld_reg = 1'b0;
      load_de(16'h0405, 16'h3008); cyc();
      ld_de = 1'b0; #1;
      chk("br dep", {31'b0, dep_stall}, 32'h1);
      chk("br ctl", {31'b0, v_de_br_stall}, 32'h1);
      cyc();
      chk("br dep clear", {31'b0, dep_stall}, 32'h0);
      chk("br ctl held", {31'b0, v_de_br_stall}, 32'h1);
      cyc();
      chk("br issue", {31'b0, agex_v}, 32'h1);
      chk("br cc", {29'b0, agex_cc}, 32'h4);

      // mem_stall freezes AGEX while DE and RF keep moving
      mem_stall = 1'b1; load_de(16'h7283, 16'h300A);
      sr_ld_reg = 1'b1; sr_dr = 3'd1; sr_data = 16'h1234;
      for (int i = 0; i < 3; i++) begin
         cyc();
         ld_de = 1'b0; sr_ld_reg = 1'b0;
         chk("hold agex_v", {31'b0, agex_v}, 32'h1);
         chk("hold agex_ir", {16'b0, agex_ir}, 32'h0405);
         chk("hold agex_npc", {16'b0, agex_npc}, 32'h3008);
      end
      mem_stall = 1'b0; cyc();
      chk("stw issue", {31'b0, agex_v}, 32'h1);
      chk("stw ir", {16'b0, agex_ir}, 32'h7283);
      chk("stw sr1", {16'b0, agex_sr1}, 32'h00AA);
      chk("stw sr2", {16'b0, agex_sr2}, 32'h1234);
      v_mem_ld_reg = 1'b1; mem_dr = 3'd1; #1;
      chk("stw mem stall", {31'b0, dep_stall}, 32'h1);
      idle();

      // randomized traffic, checked against the model every cycle
      for (int c = 0; c < 3000; c++) begin
         cyc();
         ir = 16'($urandom);
         if ($urandom_range(0, 9) < 7) begin
            ir[11:9] = 3'($urandom_range(0, 3));
            ir[8:6]  = 3'($urandom_range(0, 3));
            ir[2:0]  = 3'($urandom_range(0, 3));
         end
         ld_de        = ($urandom_range(0, 3) != 0);
         de_ir_in     = ir;
         de_npc_in    = 16'($urandom);
         de_v_in      = ($urandom_range(0, 4) != 0);
         mem_stall    = ($urandom_range(0, 4) == 0);
         v_mem_ld_reg = ($urandom_range(0, 3) == 0);
         mem_dr       = 3'($urandom_range(0, 3));
         v_mem_ld_cc  = ($urandom_range(0, 4) == 0);
         sr_ld_reg    = ($urandom_range(0, 9) < 4);
         sr_dr        = 3'($urandom_range(0, 7));
         sr_ld_cc     = ($urandom_range(0, 9) < 3);
         case ($urandom_range(0, 3))
            0: sr_data = 16'h0000;
            1: sr_data = 16'h8000 | 16'($urandom);
            default: sr_data = 16'($urandom);
         endcase
      end
      idle();

      // asynchronous reset mid-stall
      load_de(16'hE000, 16'h4000); cyc();
      ld_de = 1'b0; cyc();
      mem_stall = 1'b1; load_de(16'h1000, 16'h4002); cyc();
      ld_de = 1'b0; #1;
      chk("pre-rst stall", {31'b0, dep_stall}, 32'h1);
      chk("pre-rst agex_v", {31'b0, agex_v}, 32'h1);
      rst_n = 1'b0; #1;
      chk("mid rst agex_v", {31'b0, agex_v}, 32'h0);
      chk("mid rst agex_cc", {29'b0, agex_cc}, 32'h2);
      chk("mid rst dep", {31'b0, dep_stall}, 32'h0);
      #1 rst_n = 1'b1;
      idle();
      load_de(16'h1345, 16'h4004); cyc();
      ld_de = 1'b0; cyc();
      chk("post rst R5 sr1", {16'b0, agex_sr1}, 32'h0);
      chk("post rst R5 sr2", {16'b0, agex_sr2}, 32'h0);
      chk("post rst issue", {31'b0, agex_v}, 32'h1);
      cyc();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
